alu_mul_seq: RTL and testbench

- Multi-cycle shift-add multiply sequencer that borrows the shared 16-bit ALU for its add and subtract steps.
- Sits beside the execute stage. Receives a multiply command and issues ALU add operations one multiplier bit per cycle.
- Requests the ALU only in cycles that need it; the pipeline arbiter grants it through a req/gnt pair.
- Returns a 16-bit product (low half) plus a sticky overflow flag.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 214 +++++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_NAND  = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SHIFT = 4'b0100;

  // ABS_A, ABS_B and NEG are only reachable in the signed build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    DONE  = 3'd2,
    ABS_A = 3'd3,
    ABS_B = 3'd4,
    NEG   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer borrowing the shared ALU one multiplier bit per cycle.
// Define ALU_MUL_SIGNED_EN for two's-complement signed multiply (ABS_A/ABS_B/NEG states).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic             alu_llb,
  output logic             alu_lhb,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             ovf_r;

  logic [WIDTH-1:0] mplier_sh;
  logic [WIDTH-1:0] acc_step;
  logic             last_step;
  logic             ovf_step;
  logic             step_go;
  logic             ovf_fin;

`ifdef ALU_MUL_SIGNED_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
  logic             sign_neg;
  logic [WIDTH-1:0] abs_b;
  logic             mag_ovf;
  logic             needs_neg;
`endif

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign alu_llb = 1'b0;
  assign alu_lhb = 1'b0;

  // Next values for one shift-add step; applied only when step_go is true.
  always_comb begin
    mplier_sh = mplier >> 1;
    last_step = (mplier_sh == ZERO);
    acc_step  = mplier[0] ? alu_result : acc;
    step_go   = ~mplier[0] | alu_gnt;
    ovf_step  = ovf_r | (mplier[0] & (alu_result < acc)) |
                (mcand[WIDTH-1] & ~last_step);
`ifdef ALU_MUL_SIGNED_EN
    abs_b     = mplier[WIDTH-1] ? alu_result : mplier;
    // |-2^(WIDTH-1)| is the one magnitude above MAX_POS that still fits when negative.
    mag_ovf   = (acc_step > MAX_POS) & ~((acc_step == MIN_MAG) & sign_neg);
    needs_neg = sign_neg & (acc_step != ZERO);
    ovf_fin   = ovf_step | mag_ovf;
`else
    ovf_fin   = ovf_step;
`endif
  end

  // ALU request and operands decoded from state; never depends on alu_gnt.
  always_comb begin
    alu_req  = 1'b0;
    alu_a    = ZERO;
    alu_b    = ZERO;
    alu_ctrl = ALU_ADD;
    case (state)
      STEP: begin
        if (mplier[0]) begin
          alu_req = 1'b1;
          alu_a   = acc;
          alu_b   = mcand;
        end else begin
          alu_req = 1'b0;
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      ABS_A: begin
        if (mcand[WIDTH-1]) begin
          alu_req  = 1'b1;
          alu_b    = mcand;
          alu_ctrl = ALU_SUB;
        end else begin
          alu_req  = 1'b0;
        end
      end
      ABS_B: begin
        if (mplier[WIDTH-1]) begin
          alu_req  = 1'b1;
          alu_b    = mplier;
          alu_ctrl = ALU_SUB;
        end else begin
          alu_req  = 1'b0;
        end
      end
      NEG: begin
        alu_req  = 1'b1;
        alu_b    = acc;
        alu_ctrl = ALU_SUB;
      end
`endif
      default: alu_req = 1'b0;
    endcase
  end

  // Sequencer FSM and datapath registers; product/ovf load on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= ZERO;
      mplier  <= ZERO;
      acc     <= ZERO;
      ovf_r   <= 1'b0;
      product <= ZERO;
      ovf     <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
      sign_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= ZERO;
            ovf_r  <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
            sign_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            state    <= ABS_A;
`else
            if (op_b == ZERO) begin
              state   <= DONE;
              product <= ZERO;
              ovf     <= 1'b0;
            end else begin
              state   <= STEP;
            end
`endif
          end
        end
`ifdef ALU_MUL_SIGNED_EN
        ABS_A: begin
          if (!mcand[WIDTH-1]) begin
            state <= ABS_B;
          end else if (alu_gnt) begin
            mcand <= alu_result;
            state <= ABS_B;
          end
        end
        ABS_B: begin
          if (!mplier[WIDTH-1] || alu_gnt) begin
            mplier <= abs_b;
            if (abs_b == ZERO) begin
              state   <= DONE;
              product <= ZERO;
              ovf     <= 1'b0;
            end else begin
              state   <= STEP;
            end
          end
        end
        NEG: begin
          if (alu_gnt) begin
            acc     <= alu_result;
            product <= alu_result;
            ovf     <= ovf_r;
            state   <= DONE;
          end
        end
`endif
        STEP: begin
          if (step_go) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            ovf_r  <= ovf_fin;
            if (last_step) begin
`ifdef ALU_MUL_SIGNED_EN
              if (needs_neg) begin
                state <= NEG;
              end else begin
                state   <= DONE;
                product <= acc_step;
                ovf     <= ovf_fin;
              end
`else
              state   <= DONE;
              product <= acc_step;
              ovf     <= ovf_fin;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq; signed cases run when ALU_MUL_SIGNED_EN is defined.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_llb;
  logic        alu_lhb;
  logic [15:0] alu_result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] p;
    logic        o;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .ovf(ovf),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_llb(alu_llb), .alu_lhb(alu_lhb),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Reference ALU: only ADD and SUB are used by the sequencer.
  assign alu_result = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  function automatic int bit_len(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = 16'h0; op_b = 16'h0; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (product !== 16'h0) begin bad++; $display("FAIL reset_product got=%h exp=0000", product); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if ({alu_req, alu_a, alu_b, alu_ctrl, alu_llb, alu_lhb} !== 39'h0) begin
      bad++; $display("FAIL reset_alu got req=%b a=%h b=%h ctrl=%h exp all zero", alu_req, alu_a, alu_b, alu_ctrl);
    end
    rst = 1'b0;
  endtask

  // One multiply: push expectation, drive start, serve grants, pop and compare on done.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int deny,
                         input bit hold_start, input string name);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          reqs;
    int          denied;
    bit          prev_denied;
    bit          seen;
    logic [15:0] last_a;
    logic [31:0] full;
`ifdef ALU_MUL_SIGNED_EN
    logic signed [31:0] fs;
    logic [15:0] mag_b;
    bit          neg_run;
    fs      = $signed(a) * $signed(b);
    full    = fs;
    mag_b   = b[15] ? (16'd0 - b) : b;
    neg_run = (a[15] ^ b[15]) && (full[15:0] != 16'h0) && (mag_b != 16'h0);
    e.p     = full[15:0];
    e.o     = (fs > 32767) || (fs < -32768);
    e.lat   = bit_len(mag_b) + 3 + (neg_run ? 1 : 0) + deny;
    e.reqs  = $countones(mag_b) + int'(a[15]) + int'(b[15]) + (neg_run ? 1 : 0) + deny;
`else
    full    = {16'h0, a} * {16'h0, b};
    e.p     = full[15:0];
    e.o     = (full[31:16] != 16'h0);
    e.lat   = bit_len(b) + 1 + deny;
    e.reqs  = $countones(b) + deny;
`endif
    sb.push_back(e);
    op_a = a; op_b = b; start = 1'b1; alu_gnt = 1'b1;
    cyc = 0; reqs = 0; denied = 0; prev_denied = 0; seen = 0; last_a = 16'h0;
    for (int g = 0; g < 200 && !seen; g++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hold_start) begin
        op_a = 16'($urandom); op_b = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      if (prev_denied) begin
        total++;
        if (alu_req !== 1'b1 || alu_a !== last_a) begin
          bad++; $display("FAIL %s_hold got req=%b a=%h exp req=1 a=%h", name, alu_req, alu_a, last_a);
        end
      end
      if (alu_req === 1'b1) reqs++;
      if (alu_req === 1'b1 && denied < deny) begin
        alu_gnt = 1'b0; denied++; prev_denied = 1; last_a = alu_a;
      end else begin
        alu_gnt = 1'b1; prev_denied = 0;
      end
      if (done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s_timeout got no done exp done within 200 cycles", name);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      total++; if (product !== got.p) begin bad++; $display("FAIL %s_product got=%h exp=%h", name, product, got.p); end
      total++; if (ovf !== got.o) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, got.o); end
      total++; if (cyc != got.lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, got.lat); end
      total++; if (reqs != got.reqs) begin bad++; $display("FAIL %s_reqs got=%0d exp=%0d", name, reqs, got.reqs); end
    end
    @(posedge clk);
    #1;
    start = 1'b0; alu_gnt = 1'b1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL %s_idle got busy=%b done=%b exp 0 0", name, busy, done);
    end
  endtask

  task automatic test_unsigned();
    run_mul(16'd3, 16'd5, 0, 1'b0, "mul3x5");
    run_mul(16'h1234, 16'h0000, 0, 1'b0, "mul_by_zero");
    run_mul(16'h0100, 16'h0100, 0, 1'b0, "ovf_shift");
    run_mul(16'hFFFF, 16'h0002, 0, 1'b0, "ovf_carry");
  endtask

  task automatic test_gnt_stall();
    run_mul(16'd7, 16'd3, 3, 1'b0, "stall7x3");
  endtask

  task automatic test_back_to_back();
    run_mul(16'd9, 16'd11, 0, 1'b1, "start_ignored");
    run_mul(16'd12, 16'd10, 0, 1'b0, "b2b");
  endtask

  task automatic test_reset_mid_op();
    bit early;
    op_a = 16'h00FF; op_b = 16'h00FF; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
    total++; if (product !== 16'h0) begin bad++; $display("FAIL midrst_product got=%h exp=0000", product); end
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) early = 1;
    end
    total++; if (early) begin bad++; $display("FAIL midrst_resume got=activity exp=idle"); end
    run_mul(16'd2, 16'd2, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_mul(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'h00FF)),
              int'($urandom_range(0, 2)), 1'b0, "rand");
    end
  endtask

`ifdef ALU_MUL_SIGNED_EN
  task automatic test_signed();
    run_mul(16'hFFFD, 16'd7, 0, 1'b0, "s_neg3x7");
    run_mul(16'h8000, 16'd1, 0, 1'b0, "s_min_x1");
    run_mul(16'hFFFD, 16'hFFF9, 1, 1'b0, "s_negxneg");
    run_mul(16'h4000, 16'd2, 0, 1'b0, "s_ovf_pos");
    run_mul(16'hC000, 16'd2, 0, 1'b0, "s_min_exact");
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_gnt_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
`ifdef ALU_MUL_SIGNED_EN
    test_signed();
`endif
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_empty got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
